// File: rtl/conv_pkg.sv
// Shared constants, types and helpers for the 3x3 convolution MAC datapath.
// Byte lane k of a window carries input_layer position win_<row>_<col>, with lane = row*3 + (2-col).
package conv_pkg;

    localparam int PIX_W             = 8;
    localparam int LANES             = 9;
    localparam int STREAM_DATA_WIDTH = PIX_W * LANES;
    localparam int ACC_W             = 24;
    localparam int PROD_W            = 16;

    localparam int LANE_WIN_0_2 = 0;
    localparam int LANE_WIN_0_1 = 1;
    localparam int LANE_WIN_0_0 = 2;
    localparam int LANE_WIN_1_2 = 3;
    localparam int LANE_WIN_1_1 = 4;
    localparam int LANE_WIN_1_0 = 5;
    localparam int LANE_WIN_2_2 = 6;
    localparam int LANE_WIN_2_1 = 7;
    localparam int LANE_WIN_2_0 = 8;

    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    function automatic int win_lane(input int row, input int col);
        int lane;
        lane = LANE_WIN_1_1;
        case ({row[1:0], col[1:0]})
            4'b0000: lane = LANE_WIN_0_0;
            4'b0001: lane = LANE_WIN_0_1;
            4'b0010: lane = LANE_WIN_0_2;
            4'b0100: lane = LANE_WIN_1_0;
            4'b0101: lane = LANE_WIN_1_1;
            4'b0110: lane = LANE_WIN_1_2;
            4'b1000: lane = LANE_WIN_2_0;
            4'b1001: lane = LANE_WIN_2_1;
            4'b1010: lane = LANE_WIN_2_2;
            default: lane = LANE_WIN_1_1;
        endcase
        return lane;
    endfunction

    // Unsigned pixel times signed weight; the full product range fits in 16 bits.
    function automatic prod_t pix_mul(input logic [PIX_W-1:0] pix,
                                      input logic signed [PIX_W-1:0] wt);
        prod_t p_ext;
        prod_t w_ext;
        p_ext = {{(PROD_W-PIX_W){1'b0}}, pix};
        w_ext = {{(PROD_W-PIX_W){wt[PIX_W-1]}}, wt};
        return p_ext * w_ext;
    endfunction

endpackage

// File: rtl/conv3x3_adder_tree.sv
// Registered 9->3->1 reduction: partial sums of lane triplets, then total plus bias with optional ReLU.
// Both register stages hold while advance is low so the global stall freezes the whole pipe.
module conv3x3_adder_tree
    import conv_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  advance,
    input  logic  in_valid,
    input  prod_t in_prod [LANES],
    input  acc_t  in_bias,
    input  logic  in_relu,
    output acc_t  out_data,
    output logic  out_valid
);

    logic s2_valid_q, s2_valid_d;
    acc_t part_q [3];
    acc_t part_d [3];
    acc_t s2_bias_q, s2_bias_d;
    logic s2_relu_q, s2_relu_d;

    acc_t out_data_q, out_data_d;
    logic out_valid_q, out_valid_d;
    acc_t total;

    always_comb begin
        s2_valid_d = s2_valid_q;
        part_d     = part_q;
        s2_bias_d  = s2_bias_q;
        s2_relu_d  = s2_relu_q;
        if (advance) begin
            s2_valid_d = in_valid;
            s2_bias_d  = in_bias;
            s2_relu_d  = in_relu;
            for (int g = 0; g < 3; g++) begin
                part_d[g] = acc_t'(in_prod[3*g]) + acc_t'(in_prod[3*g+1]) + acc_t'(in_prod[3*g+2]);
            end
        end
    end

    // ReLU only inspects the sign bit of the biased total.
    always_comb begin
        total       = part_q[0] + part_q[1] + part_q[2] + s2_bias_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (advance) begin
            out_valid_d = s2_valid_q;
            out_data_d  = (s2_relu_q && total[ACC_W-1]) ? '0 : total;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q  <= 1'b0;
            s2_bias_q   <= '0;
            s2_relu_q   <= 1'b0;
            for (int g = 0; g < 3; g++) begin
                part_q[g] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s2_valid_q  <= s2_valid_d;
            part_q      <= part_d;
            s2_bias_q   <= s2_bias_d;
            s2_relu_q   <= s2_relu_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: rtl/conv3x3_mac.sv
// 3x3 window dot product against loadable signed weights, plus bias and optional ReLU.
// Three-stage pipeline with one global stall; a frame counter marks the last result of each frame.
module conv3x3_mac
    import conv_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [STREAM_DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_rdy,
    input  logic                         cfg_load,
    input  logic [STREAM_DATA_WIDTH-1:0] cfg_weights,
    input  logic [ACC_W-1:0]             cfg_bias,
    input  logic                         cfg_relu_en,
    input  logic [CNT_W-1:0]             frame_len,
    input  logic                         start,
    output logic [ACC_W-1:0]             out_data,
    output logic                         out_valid,
    output logic                         out_last,
    input  logic                         out_rdy
);

    logic stall;
    logic handshake;

    logic [STREAM_DATA_WIDTH-1:0] weights_q, weights_d;
    acc_t                         bias_q, bias_d;
    logic                         relu_en_q, relu_en_d;

    logic  s1_valid_q, s1_valid_d;
    prod_t prod_q [LANES];
    prod_t prod_d [LANES];
    acc_t  s1_bias_q, s1_bias_d;
    logic  s1_relu_q, s1_relu_d;

    logic [CNT_W-1:0] count_q, count_d;

    acc_t tree_data;

    assign stall     = out_valid & ~out_rdy;
    assign in_rdy    = ~stall;
    assign handshake = out_valid & out_rdy;

    always_comb begin
        weights_d = weights_q;
        bias_d    = bias_q;
        relu_en_d = relu_en_q;
        if (cfg_load) begin
            weights_d = cfg_weights;
            bias_d    = cfg_bias;
            relu_en_d = cfg_relu_en;
        end
    end

    // Bias and ReLU enable travel with the window so later cfg_load pulses cannot touch it.
    always_comb begin
        s1_valid_d = s1_valid_q;
        prod_d     = prod_q;
        s1_bias_d  = s1_bias_q;
        s1_relu_d  = s1_relu_q;
        if (!stall) begin
            s1_valid_d = in_valid;
            s1_bias_d  = bias_q;
            s1_relu_d  = relu_en_q;
            for (int k = 0; k < LANES; k++) begin
                prod_d[k] = pix_mul(in_data[k*PIX_W +: PIX_W], weights_q[k*PIX_W +: PIX_W]);
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (start) begin
            count_d = '0;
        end else if (handshake) begin
            count_d = out_last ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            weights_q  <= '0;
            bias_q     <= '0;
            relu_en_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_bias_q  <= '0;
            s1_relu_q  <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                prod_q[k] <= '0;
            end
            count_q    <= '0;
        end else begin
            weights_q  <= weights_d;
            bias_q     <= bias_d;
            relu_en_q  <= relu_en_d;
            s1_valid_q <= s1_valid_d;
            prod_q     <= prod_d;
            s1_bias_q  <= s1_bias_d;
            s1_relu_q  <= s1_relu_d;
            count_q    <= count_d;
        end
    end

    conv3x3_adder_tree u_tree (
        .clk       (clk),
        .reset_n   (reset_n),
        .advance   (~stall),
        .in_valid  (s1_valid_q),
        .in_prod   (prod_q),
        .in_bias   (s1_bias_q),
        .in_relu   (s1_relu_q),
        .out_data  (tree_data),
        .out_valid (out_valid)
    );

    assign out_data = tree_data;
    assign out_last = out_valid & (frame_len != '0) & (count_q == frame_len - CNT_W'(1));

endmodule

// File: tb/tb_conv3x3_mac.sv
// Self-checking bench for conv3x3_mac: directed vector table, corner-case sequences and a
// randomized run scored against a plain-arithmetic reference model.
module tb_conv3x3_mac;
    import conv_pkg::*;

    localparam int CNT_W = 16;

    logic                         clk = 1'b0;
    logic                         reset_n;
    logic [STREAM_DATA_WIDTH-1:0] in_data;
    logic                         in_valid;
    logic                         in_rdy;
    logic                         cfg_load;
    logic [STREAM_DATA_WIDTH-1:0] cfg_weights;
    logic [ACC_W-1:0]             cfg_bias;
    logic                         cfg_relu_en;
    logic [CNT_W-1:0]             frame_len;
    logic                         start;
    logic [ACC_W-1:0]             out_data;
    logic                         out_valid;
    logic                         out_last;
    logic                         out_rdy;

    always #5 clk = ~clk;

    conv3x3_mac #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_rdy      (in_rdy),
        .cfg_load    (cfg_load),
        .cfg_weights (cfg_weights),
        .cfg_bias    (cfg_bias),
        .cfg_relu_en (cfg_relu_en),
        .frame_len   (frame_len),
        .start       (start),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_rdy     (out_rdy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_result(input logic [71:0] px, input logic [71:0] wt,
                                      input int bias, input bit relu);
        int s;
        s = bias;
        for (int k = 0; k < LANES; k++) begin
            logic [7:0]        p = px[k*8 +: 8];
            logic signed [7:0] w = wt[k*8 +: 8];
            s += int'(p) * int'(w);
        end
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    // Reference model state, owned by the monitor only.
    logic [71:0] m_wts;
    int          m_bias;
    bit          m_relu;
    logic [15:0] m_cnt;
    int          exp_q[$];
    int          res_q[$];
    bit          last_q[$];
    bit          prev_stall;
    logic [23:0] prev_data;
    logic        prev_last;
    int          sb_e;
    bit          sb_last;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            m_wts      = '0;
            m_bias     = 0;
            m_relu     = 1'b0;
            m_cnt      = '0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_data", out_data, prev_data);
                checkOutput("hold_last", out_last, prev_last);
            end
            checkOutput("in_rdy", in_rdy, !(out_valid && !out_rdy));
            if (!out_valid) checkOutput("last_without_valid", out_last, 0);
            if (out_valid && out_rdy) begin
                sb_last = (frame_len != 0) && (m_cnt == frame_len - 16'd1);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_result", 1, 0);
                end else begin
                    sb_e = exp_q.pop_front();
                    checkOutput("sb_data", int'($signed(out_data)), sb_e);
                    checkOutput("sb_last", out_last, sb_last);
                end
                res_q.push_back(int'($signed(out_data)));
                last_q.push_back(out_last);
                if (start || sb_last) m_cnt = '0;
                else                  m_cnt = m_cnt + 16'd1;
            end else if (start) begin
                m_cnt = '0;
            end
            if (in_valid && in_rdy) exp_q.push_back(ref_result(in_data, m_wts, m_bias, m_relu));
            if (cfg_load) begin
                m_wts  = cfg_weights;
                m_bias = int'($signed(cfg_bias));
                m_relu = cfg_relu_en;
            end
            prev_stall = out_valid && !out_rdy;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    typedef struct {
        logic [71:0] pix;
        logic [71:0] wts;
        logic [23:0] bias;
        bit          relu;
        int          exp;
    } vec_t;

    vec_t vecs[15];

    // Sends one window from posedge+1 and waits for its result; returns cycles to out_valid.
    task automatic sendOne(input logic [71:0] px, output int lat);
        in_valid = 1'b1;
        in_data  = px;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        if (!out_valid) checkOutput("result_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic loadCfg(input logic [71:0] w, input logic [23:0] b, input bit r);
        cfg_load    = 1'b1;
        cfg_weights = w;
        cfg_bias    = b;
        cfg_relu_en = r;
        @(posedge clk); #1;
        cfg_load    = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int lat;
        int base;
        loadCfg(v.wts, v.bias, v.relu);
        base = res_q.size();
        sendOne(v.pix, lat);
        if (res_q.size() > base) checkOutput($sformatf("vec%0d_data", idx), res_q[base], v.exp);
        else                     checkOutput($sformatf("vec%0d_missing", idx), 0, 1);
        checkOutput($sformatf("vec%0d_latency", idx), lat, 3);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic frameRun(input logic [15:0] flen, input int start_after, input int l0, input int l1,
                            input string tag);
        int lat;
        int base;
        frame_len = flen;
        pulseStart();
        base = last_q.size();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] b = 8'(i + 3);
            sendOne({9{b}}, lat);
            if (i + 1 == start_after) pulseStart();
        end
        checkOutput({tag, "_count"}, last_q.size() - base, 10);
        for (int i = 0; i < 10 && base + i < last_q.size(); i++) begin
            checkOutput($sformatf("%s_last%0d", tag, i + 1), last_q[base + i], (i == l0 || i == l1));
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int base;
        int cyc;
        int idx;
        int hold_cnt;
        int vcnt;
        int b;
        bit acc;
        logic [23:0] held;
        logic [71:0] tp;
        logic [71:0] tw;
        logic [7:0]  bb;

        reset_n     = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        cfg_load    = 1'b0;
        cfg_weights = '0;
        cfg_bias    = '0;
        cfg_relu_en = 1'b0;
        frame_len   = '0;
        start       = 1'b0;
        out_rdy     = 1'b1;

        vecs[0] = '{{9{8'hFF}}, {9{8'h01}}, 24'd0, 1'b0, 2295};
        vecs[1] = '{{9{8'hFF}}, {9{8'h80}}, 24'd0, 1'b0, -293760};
        vecs[2] = '{{9{8'hFF}}, {9{8'h80}}, 24'd0, 1'b1, 0};
        vecs[3] = '{{9{8'h00}}, {9{8'h7F}}, 24'd1000, 1'b0, 1000};
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int k;
                k  = win_lane(r, c);
                tp = '0;
                tw = '0;
                tp[k*8 +: 8] = 8'h0A;
                tw[k*8 +: 8] = 8'hFD;
                vecs[4 + r*3 + c] = '{tp, tw, 24'd0, 1'b0, -30};
            end
        end
        tp = '0; tw = '0; tp[0 +: 8] = 8'h0A;  tw[8 +: 8]  = 8'hFD;
        vecs[13] = '{tp, tw, 24'd0, 1'b0, 0};
        tp = '0; tw = '0; tp[56 +: 8] = 8'h0A; tw[64 +: 8] = 8'hFD;
        vecs[14] = '{tp, tw, 24'd0, 1'b0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_last", out_last, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_in_rdy", in_rdy, 1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] weights cleared by reset");
        base = res_q.size();
        sendOne({9{8'hFF}}, lat);
        if (res_q.size() > base) checkOutput("reset_weights_zero", res_q[base], 0);
        else                     checkOutput("reset_weights_missing", 0, 1);

        $display("[TB] directed vector table");
        for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

        $display("[TB] cfg_load between back-to-back windows");
        loadCfg({9{8'h01}}, 24'd0, 1'b0);
        base        = res_q.size();
        in_valid    = 1'b1;
        in_data     = {9{8'h01}};
        cfg_load    = 1'b1;
        cfg_weights = {9{8'h02}};
        @(posedge clk); #1;
        cfg_load    = 1'b0;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        vcnt = 0;
        while (res_q.size() < base + 2 && vcnt < 20) begin
            @(posedge clk); #1;
            vcnt++;
        end
        if (res_q.size() >= base + 2) begin
            checkOutput("cfg_old_weights", res_q[base], 9);
            checkOutput("cfg_new_weights", res_q[base + 1], 18);
        end else begin
            checkOutput("cfg_results_timeout", res_q.size() - base, 2);
        end

        $display("[TB] backpressure hold");
        loadCfg({9{8'h01}}, 24'd0, 1'b0);
        base = res_q.size();
        cyc = 0; idx = 0; hold_cnt = 0; held = '0;
        while (idx < 20 && cyc < 200) begin
            bb       = 8'(idx + 1);
            in_valid = 1'b1;
            in_data  = {9{bb}};
            out_rdy  = !(cyc >= 4 && cyc < 14);
            @(negedge clk);
            acc = in_rdy;
            if (!in_rdy) hold_cnt++;
            if (cyc == 4) begin
                held = out_data;
                checkOutput("bp_held_value", int'($signed(out_data)), 18);
            end else if (cyc > 4 && cyc < 14) begin
                checkOutput($sformatf("bp_in_rdy_c%0d", cyc), in_rdy, 0);
                checkOutput($sformatf("bp_stable_c%0d", cyc), out_data, held);
            end
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        out_rdy  = 1'b1;
        vcnt = 0;
        while (res_q.size() < base + 20 && vcnt < 50) begin
            @(posedge clk); #1;
            vcnt++;
        end
        checkOutput("bp_hold_cycles", hold_cnt, 10);
        checkOutput("bp_result_count", res_q.size() - base, 20);
        for (int i = 0; i < 20 && base + i < res_q.size(); i++) begin
            checkOutput($sformatf("bp_order%0d", i), res_q[base + i], 9 * (i + 1));
        end

        $display("[TB] frame marker");
        frameRun(16'd4, 0, 3, 7, "frame4");
        frameRun(16'd4, 2, 5, 9, "frame4_start");
        frameRun(16'd0, 0, -1, -1, "frame0");

        $display("[TB] randomized traffic");
        frame_len = 16'd5;
        pulseStart();
        for (int i = 0; i < 1500; i++) begin
            out_rdy  = ($urandom_range(0, 3) != 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = {$urandom(), $urandom(), 8'($urandom())};
            cfg_load = ($urandom_range(0, 19) == 0);
            if (cfg_load) begin
                cfg_weights = {$urandom(), $urandom(), 8'($urandom())};
                b           = int'($urandom_range(0, 4194303)) - 2097152;
                cfg_bias    = 24'(b);
                cfg_relu_en = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        cfg_load = 1'b0;
        in_valid = 1'b0;
        out_rdy  = 1'b1;
        vcnt = 0;
        while ((exp_q.size() != 0 || out_valid) && vcnt < 50) begin
            @(posedge clk); #1;
            vcnt++;
        end
        checkOutput("random_drain", exp_q.size(), 0);

        $display("[TB] reset mid-stream");
        loadCfg({9{8'h01}}, 24'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bb       = 8'(i + 1);
            in_valid = 1'b1;
            in_data  = {9{bb}};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_out_data", out_data, 0);
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        vcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        checkOutput("post_reset_no_stale", vcnt, 0);
        checkOutput("post_reset_pending", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv3x3_mac.md
Name: conv3x3_mac

Overview:
- Consumes the 72-bit 3x3 window stream produced by input_layer (nine unsigned 8-bit pixels per beat, valid/rdy).
- Computes one signed dot product per window against nine signed 8-bit weights, adds a bias and applies optional ReLU.
- Emits an ACC_W-bit result stream with a frame-end marker.
- Sits directly downstream of input_layer and drives its input_layer_1_rdy.

Parameters:
- PIX_W, 8, pixel and weight byte width
- LANES, 9, window taps
- STREAM_DATA_WIDTH, 72, PIX_W*LANES, input window width
- ACC_W, 24, result and bias width (signed)
- CNT_W, 16, frame window-counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_data  in  72  window; byte lane k = in_data[8k+7:8k], k=0..8, unsigned
- in_valid  in  1  window valid
- in_rdy  out  1  window accepted when in_valid & in_rdy
- cfg_load  in  1  single-cycle pulse; latch cfg_weights/cfg_bias/cfg_relu_en
- cfg_weights  in  72  signed weight per byte lane; lane k multiplies pixel lane k
- cfg_bias  in  ACC_W  signed bias
- cfg_relu_en  in  1  1 = clamp negative results to 0
- frame_len  in  CNT_W  results per frame; 0 = out_last never asserted
- start  in  1  single-cycle pulse; clears the frame counter
- out_data  out  ACC_W  signed result
- out_valid  out  1  result valid
- out_last  out  1  qualifies out_valid; marks the last result of a frame
- out_rdy  in  1  downstream ready

Behaviour:
- Reset (async, reset_n low): all stage valids = 0; out_valid, out_last and out_data = 0; weights, bias and relu_en = 0; frame counter = 0. Reset mid-stream drops in-flight windows with no partial output.
- Pipeline has 3 registered stages with a global stall. stall = out_valid & ~out_rdy. in_rdy = ~stall (combinational from out_rdy). All stages advance when ~stall. Bubbles advance; they do not compress.
- S1: 9 products, pixel (zero-extended to 9b) × weight (s8) into s16. Range -32640..32385, no overflow. Bias and relu_en sampled here and carried with the window.
- S2: three partial sums of lanes {0,1,2}, {3,4,5}, {6,7,8}, sign-extended to ACC_W.
- S3: sum of the partials + bias. If relu_en and the result is negative, output 0. Write into the out_data/out_valid registers.
- Latency: a window accepted in cycle N appears on out_data in cycle N+3 when unstalled. Throughput is 1 window/cycle.
- Arithmetic: all signed two's complement at ACC_W. Maximum |dot| is 293760 < 2^19, so no saturation is needed with ACC_W ≥ 21.
- Config timing: cfg_load in cycle N updates the registers at edge N. Windows accepted in cycle N+1 onward use the new values; windows already in flight keep their own weights and bias. cfg_load is allowed at any time.
- Frame counter: increments on each out_valid & out_rdy handshake.
  - out_last = out_valid & (frame_len != 0) & (count == frame_len-1).
  - The counter wraps to 0 on the handshake that carries out_last.
  - start clears the counter. If start coincides with a handshake, start wins (count = 0).
- Holding: while stalled, out_data, out_valid and out_last are stable. in_valid with in_rdy low is ignored; upstream holds the data.

Decomposition:
- Shared package conv_pkg holds PIX_W, LANES, STREAM_DATA_WIDTH, ACC_W and PROD_W=16, plus the lane-index constants mapping input_layer window positions to byte lanes (lane 0 = win_0_2 … lane 8 = win_2_0).
- One natural sub-module: conv3x3_adder_tree, a registered 9→3→1 reduction covering S2 and S3 sums.
- Multipliers and the counter stay in conv3x3_mac.

Test Plan:
- Weights all +1, bias 0, relu off; window all 0xFF → out_data = 2295, exactly 3 cycles after the accept.
- Weights all -128 (0x80), pixels all 255: relu off → -293760; relu on → 0. Bias +1000 with all-zero pixels → 1000.
- Lane isolation: for k = 0..8, only pixel lane k = 10 and only weight lane k = -3 → -30 each. A mismatched lane (pixel k, weight k+1) → 0.
- Backpressure: continuous in_valid, out_rdy low for 10 cycles → in_rdy low and out_data stable during the hold. After release, the full sequence of 20 distinct windows emerges in order with no loss or duplication.
- Frame marker: frame_len = 4, 10 results → out_last on results 4 and 8 only. start pulsed after result 2 → next out_last on result 6. frame_len = 0 → out_last never asserted.
- Config/reset: cfg_load of new weights between two back-to-back windows → the first result uses the old weights, the second the new. reset_n low mid-stream with 2 in flight → out_valid = 0 immediately; no stale result after reset release.
